// File: rtl/seg7_pkg.sv
// seg7_pkg: register addresses, blank pattern and hex segment table shared by the seg7_bank files
package seg7_pkg;
  localparam logic [3:0] ADDR_CTRL = 4'd8;
  localparam logic [3:0] ADDR_SCROLL = 4'd9;
  localparam logic [3:0] ADDR_STATUS = 4'd10;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] HEX_SEG [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: digit register {mode,value} + lit flag -> 8-bit segment pattern, polarity applied last
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1
) (
  input  logic [8:0] digit,
  input  logic       lit,
  output logic [7:0] seg
);
  logic [7:0] pat;
  always_comb begin
    pat = !lit ? SEG_OFF : digit[8] ? digit[7:0] : HEX_SEG[digit[3:0]] | {digit[7], 7'b0};
    seg = ACTIVE_LOW ? ~pat : pat;
  end
endmodule

// File: rtl/seg7_bank.sv
// seg7_bank: Avalon-MM slave (clk, reset, avs_*) driving NUM_DIGITS seven-segment digits on seg_out with blink, blank and scroll
module seg7_bank
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter bit ACTIVE_LOW = 1,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [8*NUM_DIGITS-1:0] seg_out
);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [7:0] MASK_VALID = 8'((9'd1 << NUM_DIGITS) - 9'd1);
  localparam logic [8*NUM_DIGITS-1:0] SEG_RST = {8*NUM_DIGITS{ACTIVE_LOW}};
  logic [NUM_DIGITS-1:0][8:0] dig, dig_nxt;
  logic [8*NUM_DIGITS-1:0] seg_nxt;
  logic [7:0] mask;
  logic [CW-1:0] cnt;
  logic [31:0] rd;
  logic en, phase;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [8:0] prev;
    if (g == 0) begin : g_first
      assign prev = avs_writedata[8:0];
    end else begin : g_rest
      assign prev = dig[g-1];
    end
    assign dig_nxt[g] = !avs_write ? dig[g] :
                        avs_address == 4'(g) ? avs_writedata[8:0] :
                        avs_address == ADDR_SCROLL ? prev : dig[g];
    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .digit(dig[g]),
      .lit  (en & ~(mask[g] & phase)),
      .seg  (seg_nxt[8*g +: 8])
    );
  end
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (avs_address == 4'(i)) rd = {23'b0, dig[i]};
    if (avs_address == ADDR_CTRL) rd = {en, 23'b0, mask};
    if (avs_address == ADDR_STATUS) rd = {31'b0, phase};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig <= '0;
      en <= 1'b0;
      mask <= '0;
      cnt <= '0;
      phase <= 1'b0;
      avs_readdata <= '0;
      seg_out <= SEG_RST;
    end else begin
      dig <= dig_nxt;
      if (avs_write && avs_address == ADDR_CTRL) begin
        en <= avs_writedata[31];
        mask <= avs_writedata[7:0] & MASK_VALID;
      end
      cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      if (cnt == CNT_MAX) phase <= ~phase;
      if (avs_read) avs_readdata <= rd;
      seg_out <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_seg7_bank.sv
// tb_seg7_bank: randomized and directed checks of seg7_bank (8- and 4-digit instances) against a behavioural model
module tb_seg7_bank;
  logic clk = 0, reset = 0, avs_write = 0, avs_read = 0;
  logic [3:0] avs_address = '0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] rd8, rd4;
  logic [63:0] seg8;
  logic [31:0] seg4;
  always #5 clk = ~clk;
  seg7_bank #(.NUM_DIGITS(8), .ACTIVE_LOW(1), .BLINK_DIV(4)) dut8 (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(rd8), .seg_out(seg8)
  );
  seg7_bank #(.NUM_DIGITS(4), .ACTIVE_LOW(1), .BLINK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(rd4), .seg_out(seg4)
  );
  logic [6:0] hexs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int n_chk = 0, n_pass = 0, kk = 0;
  logic [8:0] md [2][8];
  logic men [2];
  logic [7:0] mmask [2];
  logic [31:0] erd [2];
  logic [63:0] eseg [2];
  function automatic int nd(int u);
    return u == 0 ? 8 : 4;
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [63:0] mseg_all(int u);
    logic [63:0] r = '0;
    logic [7:0] p;
    int ph = (kk / 4) % 2;
    for (int i = 0; i < nd(u); i++) begin
      p = md[u][i][8] ? md[u][i][7:0] : {md[u][i][7], hexs[md[u][i][3:0]]};
      if (!men[u] || (mmask[u][i] && ph == 1)) p = 8'h00;
      r[8*i +: 8] = ~p;
    end
    return r;
  endfunction
  function automatic logic [31:0] mread(int u, int a);
    if (a < nd(u)) return {23'b0, md[u][a]};
    if (a == 8) return {men[u], 23'b0, mmask[u]};
    if (a == 10) return 32'((kk / 4) % 2);
    return 0;
  endfunction
  task automatic mwrite(int u, int a, logic [31:0] d);
    if (a < nd(u)) md[u][a] = d[8:0];
    else if (a == 8) begin
      men[u] = d[31];
      mmask[u] = d[7:0] & 8'((1 << nd(u)) - 1);
    end else if (a == 9) begin
      for (int k = nd(u) - 1; k > 0; k--) md[u][k] = md[u][k-1];
      md[u][0] = d[8:0];
    end
  endtask
  task automatic mreset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 8; i++) md[u][i] = '0;
      men[u] = 0;
      mmask[u] = '0;
      erd[u] = '0;
      eseg[u] = u == 0 ? '1 : 64'h0000_0000_FFFF_FFFF;
    end
    kk = 0;
  endtask
  task automatic cycle(logic w, logic r, int a, logic [31:0] d);
    avs_write = w;
    avs_read = r;
    avs_address = 4'(a);
    avs_writedata = d;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      eseg[u] = mseg_all(u);
      if (r) erd[u] = mread(u, a);
      if (w) mwrite(u, a, d);
    end
    kk++;
    @(negedge clk);
    avs_write = 0;
    avs_read = 0;
  endtask
  task automatic check_all(string tag);
    chk({tag, "_seg8"}, seg8, eseg[0]);
    chk({tag, "_seg4"}, {32'b0, seg4}, eseg[1]);
    chk({tag, "_rd8"}, {32'b0, rd8}, {32'b0, erd[0]});
    chk({tag, "_rd4"}, {32'b0, rd4}, {32'b0, erd[1]});
  endtask
  initial begin
    logic [31:0] d;
    int a;
    mreset();
    #2 reset = 1;
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 0;
    mreset();
    cycle(1, 0, 8, 32'h8000_0000);
    cycle(1, 0, 0, 32'h0000_000A);
    cycle(0, 0, 0, 0);
    chk("d0_hexA", {56'b0, seg8[7:0]}, 64'h88);
    cycle(0, 1, 0, 0);
    chk("rd_d0", {32'b0, rd8}, 64'hA);
    check_all("hexA");
    cycle(1, 0, 1, 32'h0000_018F);
    cycle(0, 0, 0, 0);
    chk("d1_raw", {56'b0, seg8[15:8]}, 64'h70);
    cycle(1, 0, 9, 1);
    cycle(1, 0, 9, 2);
    cycle(1, 0, 9, 3);
    cycle(0, 0, 0, 0);
    chk("scroll", {40'b0, seg8[23:0]}, 64'hF9A4B0);
    check_all("scroll");
    cycle(1, 0, 8, 32'h8000_0001);
    repeat (18) begin
      cycle(0, 1, 10, 0);
      check_all("blink");
    end
    cycle(1, 0, 6, 32'h0000_0123);
    cycle(1, 0, 8, 32'h8000_00FF);
    cycle(0, 1, 6, 0);
    chk("n4_addr6", {32'b0, rd4}, 64'h0);
    cycle(0, 1, 8, 0);
    chk("n4_mask", {32'b0, rd4}, 64'h8000_000F);
    chk("n8_mask", {32'b0, rd8}, 64'h8000_00FF);
    cycle(1, 1, 2, 32'h0000_0155);
    check_all("rw_same");
    repeat (300) begin
      a = int'($urandom_range(0, 15));
      d = $urandom;
      if (a == 8) d[31] = $urandom_range(0, 3) != 0;
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d);
      check_all("rand");
    end
    cycle(1, 0, 8, 32'h8000_0000);
    cycle(1, 0, 0, 32'h0000_0008);
    cycle(0, 0, 0, 0);
    check_all("prereset");
    #2 reset = 1;
    #1;
    chk("async_seg8", seg8, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("async_seg4", {32'b0, seg4}, 64'hFFFF_FFFF);
    chk("async_rd8", {32'b0, rd8}, 64'h0);
    @(negedge clk);
    reset = 0;
    mreset();
    for (int i = 0; i < 11; i++) begin
      cycle(0, 1, i, 0);
      check_all("post_reset");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
